// File: rtl/kt_pkg.sv
// Shared definitions for the branch-kind table update scheduler:
// kind encodings, controller states and the kind sanitising helper.
package kt_pkg;

  localparam int KIND_W = 3;

  localparam logic [KIND_W-1:0] NOT_JUMP      = 3'd0;
  localparam logic [KIND_W-1:0] DIRECT_JUMP   = 3'd1;
  localparam logic [KIND_W-1:0] CALL          = 3'd2;
  localparam logic [KIND_W-1:0] RET           = 3'd3;
  localparam logic [KIND_W-1:0] INDIRECT_JUMP = 3'd4;
  localparam logic [KIND_W-1:0] OTHER_JUMP    = 3'd5;

  typedef logic [KIND_W-1:0] kind_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Encodings above OTHER_JUMP are undefined and collapse to NOT_JUMP.
  function automatic kind_t kind_sanitize(input kind_t k);
    return (k > OTHER_JUMP) ? NOT_JUMP : k;
  endfunction

endpackage

// File: rtl/kt_upd_fifo.sv
// Pending-update FIFO. Exposes every slot and its valid bit so the
// parent can search for the youngest address match.
module kt_upd_fifo
  import kt_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 19
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       clr_i,
  input  logic [W-1:0]               din_i,
  output logic [W-1:0]               head_o,
  output logic [DEPTH-1:0][W-1:0]    entries_o,
  output logic [DEPTH-1:0]           valid_o,
  output logic [$clog2(DEPTH)-1:0]   wr_ptr_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][W-1:0]  mem_q;
  logic [PW-1:0]            rd_q, rd_d;
  logic [PW-1:0]            wr_q, wr_d;
  logic [CW-1:0]            count_q, count_d;
  logic [DEPTH-1:0][PW-1:0] age_s;

  // Pointer and occupancy next-state; clear wins over push/pop.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (clr_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (push_i) begin
        wr_d = wr_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        wr_d = wr_q;
      end
      if (pop_i) begin
        rd_d = rd_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        rd_d = rd_q;
      end
      count_d = count_q + {{PW{1'b0}}, push_i} - {{PW{1'b0}}, pop_i};
    end
  end

  // Pointer, occupancy and storage registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      mem_q   <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      if (push_i && !clr_i) begin
        mem_q[wr_q] <= din_i;
      end
    end
  end

  // A slot is live when its distance from the head is below the count.
  always_comb begin
    age_s   = '0;
    valid_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age_s[i]   = PW'(i) - rd_q;
      valid_o[i] = ({1'b0, age_s[i]} < count_q);
    end
  end

  assign head_o    = mem_q[rd_q];
  assign entries_o = mem_q;
  assign wr_ptr_o  = wr_q;
  assign count_o   = count_q;
  assign full_o    = (count_q == CW'(DEPTH));

endmodule

// File: rtl/kt_upd_ctrl.sv
// Branch-kind table update scheduler: post-reset clear sweep, buffered
// ID-stage updates drained one per cycle, and query-path forwarding.
module kt_upd_ctrl
  import kt_pkg::*;
#(
  parameter int K_WIDTH    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               upd_valid,
  input  logic [K_WIDTH-1:0] upd_pc_hash,
  input  logic [2:0]         upd_kind,
  output logic               upd_ready,
  input  logic               stall,
  input  logic               flush,
  output logic               tbl_we,
  output logic [K_WIDTH-1:0] tbl_waddr,
  output logic [2:0]         tbl_din,
  input  logic [K_WIDTH-1:0] q_pc_hash,
  input  logic [2:0]         q_kind_raw,
  output logic [2:0]         q_kind,
  output logic               init_done
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam int REC_W = K_WIDTH + KIND_W;

  typedef struct packed {
    logic [K_WIDTH-1:0] pc_hash;
    kind_t              kind;
  } upd_rec_t;

  state_e                            state_q, state_d;
  logic [K_WIDTH-1:0]                cnt_q, cnt_d;
  logic                              push_s, pop_s, clr_s, full_s;
  upd_rec_t                          push_rec_s, head_rec_s;
  logic [REC_W-1:0]                  head_s;
  logic [FIFO_DEPTH-1:0][REC_W-1:0]  entries_s;
  logic [FIFO_DEPTH-1:0]             valid_s;
  logic [PW-1:0]                     wr_ptr_s;
  logic [CW-1:0]                     count_s;
  logic [FIFO_DEPTH-1:0][PW-1:0]     fwd_idx_s;

  assign push_rec_s = '{pc_hash: upd_pc_hash, kind: kind_sanitize(upd_kind)};
  assign head_rec_s = head_s;

  kt_upd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push_i    (push_s),
    .pop_i     (pop_s),
    .clr_i     (clr_s),
    .din_i     (push_rec_s),
    .head_o    (head_s),
    .entries_o (entries_s),
    .valid_o   (valid_s),
    .wr_ptr_o  (wr_ptr_s),
    .count_o   (count_s),
    .full_o    (full_s)
  );

  // State and sweep counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and write-port decode; flush outranks stall in RUN.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tbl_we    = 1'b0;
    tbl_waddr = head_rec_s.pc_hash;
    tbl_din   = head_rec_s.kind;
    upd_ready = 1'b0;
    init_done = 1'b0;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    clr_s     = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        tbl_we    = 1'b1;
        tbl_waddr = cnt_q;
        tbl_din   = NOT_JUMP;
        cnt_d     = cnt_q + {{(K_WIDTH-1){1'b0}}, 1'b1};
        if (cnt_q == {K_WIDTH{1'b1}}) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_RUN: begin
        init_done = 1'b1;
        upd_ready = !full_s;
        if (flush) begin
          clr_s = 1'b1;
        end else begin
          push_s = upd_valid && !full_s;
          pop_s  = !stall && (count_s != '0);
        end
        tbl_we = pop_s;
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Youngest live match wins: scan from oldest to newest, last hit sticks.
  always_comb begin
    fwd_idx_s = '0;
    q_kind    = NOT_JUMP;
    if (state_q == ST_RUN) begin
      q_kind = q_kind_raw;
      for (int a = FIFO_DEPTH - 1; a >= 0; a--) begin
        fwd_idx_s[a] = wr_ptr_s - PW'(a + 1);
        if (valid_s[fwd_idx_s[a]] &&
            (entries_s[fwd_idx_s[a]][REC_W-1:KIND_W] == q_pc_hash)) begin
          q_kind = entries_s[fwd_idx_s[a]][KIND_W-1:0];
        end else begin
          q_kind = q_kind;
        end
      end
    end else begin
      q_kind = NOT_JUMP;
    end
  end

endmodule

// File: tb/tb_kt_upd_ctrl.sv
// Directed bench for kt_upd_ctrl (K_WIDTH=4, FIFO_DEPTH=4) with a
// queue-based reference model checked on every falling edge.
module tb_kt_upd_ctrl;

  localparam int KW = 4;
  localparam int D  = 4;
  localparam int N  = 16;

  logic          clk;
  logic          rstn;
  logic          upd_valid;
  logic [KW-1:0] upd_pc_hash;
  logic [2:0]    upd_kind;
  logic          upd_ready;
  logic          stall;
  logic          flush;
  logic          tbl_we;
  logic [KW-1:0] tbl_waddr;
  logic [2:0]    tbl_din;
  logic [KW-1:0] q_pc_hash;
  logic [2:0]    q_kind_raw;
  logic [2:0]    q_kind;
  logic          init_done;

  int vectors     = 0;
  int miscompares = 0;

  // Table RAM driven by the DUT write port; starts as garbage.
  logic [2:0] dut_ram [N] = '{default: 3'd7};

  // Reference model state.
  typedef struct {
    int pc;
    int kind;
  } ent_t;
  bit         m_clear = 1'b1;
  int         m_cnt   = 0;
  logic [2:0] m_ram [N] = '{default: 3'd7};
  ent_t       m_q [$];

  kt_upd_ctrl #(.K_WIDTH(KW), .FIFO_DEPTH(D)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .upd_valid   (upd_valid),
    .upd_pc_hash (upd_pc_hash),
    .upd_kind    (upd_kind),
    .upd_ready   (upd_ready),
    .stall       (stall),
    .flush       (flush),
    .tbl_we      (tbl_we),
    .tbl_waddr   (tbl_waddr),
    .tbl_din     (tbl_din),
    .q_pc_hash   (q_pc_hash),
    .q_kind_raw  (q_kind_raw),
    .q_kind      (q_kind),
    .init_done   (init_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (tbl_we) dut_ram[tbl_waddr] <= tbl_din;
  end

  assign q_kind_raw = dut_ram[q_pc_hash];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model advance: clear sweep, then flush / drain / accept rules.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_clear = 1'b1;
      m_cnt   = 0;
      m_q.delete();
    end else if (m_clear) begin
      m_ram[m_cnt] = 3'd0;
      if (m_cnt == N - 1) m_clear = 1'b0;
      m_cnt = (m_cnt + 1) % N;
    end else if (flush) begin
      m_q.delete();
    end else begin
      bit rdy;
      ent_t e;
      rdy = (m_q.size() < D);
      if (!stall && m_q.size() > 0) begin
        m_ram[m_q[0].pc] = 3'(m_q[0].kind);
        void'(m_q.pop_front());
      end
      if (upd_valid && rdy) begin
        e.pc   = int'(upd_pc_hash);
        e.kind = (upd_kind > 3'd5) ? 0 : int'(upd_kind);
        m_q.push_back(e);
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    int e_we, e_addr, e_din, e_rdy, e_init, e_qk;
    if (m_clear) begin
      e_we = 1; e_addr = m_cnt; e_din = 0; e_rdy = 0; e_init = 0; e_qk = 0;
    end else begin
      e_init = 1;
      e_rdy  = (m_q.size() < D) ? 1 : 0;
      e_we   = (!stall && !flush && m_q.size() > 0) ? 1 : 0;
      e_addr = (m_q.size() > 0) ? m_q[0].pc : 0;
      e_din  = (m_q.size() > 0) ? m_q[0].kind : 0;
      e_qk   = int'(m_ram[q_pc_hash]);
      foreach (m_q[i]) if (m_q[i].pc == int'(q_pc_hash)) e_qk = m_q[i].kind;
    end
    check("tbl_we", 32'(tbl_we), 32'(e_we));
    check("init_done", 32'(init_done), 32'(e_init));
    check("upd_ready", 32'(upd_ready), 32'(e_rdy));
    check("q_kind", 32'(q_kind), 32'(e_qk));
    if (e_we == 1) begin
      check("tbl_waddr", 32'(tbl_waddr), 32'(e_addr));
      check("tbl_din", 32'(tbl_din), 32'(e_din));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int pc, input int kind);
    upd_valid   = 1'b1;
    upd_pc_hash = KW'(pc);
    upd_kind    = 3'(kind);
    cyc();
  endtask

  initial begin
    rstn = 1'b0; upd_valid = 1'b0; upd_pc_hash = '0; upd_kind = '0;
    stall = 1'b0; flush = 1'b0; q_pc_hash = 4'd3;

    // Reset state and clear sweep.
    repeat (2) cyc();
    check("rst_we", 32'(tbl_we), 32'd1);
    check("rst_waddr", 32'(tbl_waddr), 32'd0);
    check("rst_ready", 32'(upd_ready), 32'd0);
    check("rst_qkind", 32'(q_kind), 32'd0);
    rstn = 1'b1;
    repeat (15) cyc();
    check("sweep_last_addr", 32'(tbl_waddr), 32'd15);
    check("sweep_init_lo", 32'(init_done), 32'd0);
    cyc();
    check("sweep_init_hi", 32'(init_done), 32'd1);
    check("sweep_we_off", 32'(tbl_we), 32'd0);
    for (int i = 0; i < N; i++) check("sweep_ram_zero", 32'(dut_ram[i]), 32'd0);

    // Single push, written the next cycle, forwarded then read back.
    push(5, 2);
    upd_valid = 1'b0;
    #1;
    check("p1_we", 32'(tbl_we), 32'd1);
    check("p1_waddr", 32'(tbl_waddr), 32'd5);
    check("p1_din", 32'(tbl_din), 32'd2);
    q_pc_hash = 4'd5;
    #1;
    check("p1_fwd", 32'(q_kind), 32'd2);
    cyc();
    check("p1_ram", 32'(q_kind), 32'd2);

    // Fill under stall, youngest-match forwarding, in-order drain.
    stall = 1'b1;
    push(1, 1); push(2, 3); push(3, 4); push(1, 5);
    upd_valid = 1'b0;
    #1;
    check("full_ready", 32'(upd_ready), 32'd0);
    q_pc_hash = 4'd1;
    #1;
    check("youngest", 32'(q_kind), 32'd5);
    cyc();
    stall = 1'b0;
    #1;
    check("d0_addr", 32'(tbl_waddr), 32'd1);
    check("d0_din", 32'(tbl_din), 32'd1);
    cyc();
    check("d1_ready", 32'(upd_ready), 32'd1);
    check("d1_addr", 32'(tbl_waddr), 32'd2);
    check("d1_din", 32'(tbl_din), 32'd3);
    cyc();
    check("d2_din", 32'(tbl_din), 32'd4);
    cyc();
    check("d3_addr", 32'(tbl_waddr), 32'd1);
    check("d3_din", 32'(tbl_din), 32'd5);
    cyc();
    check("drain_done", 32'(tbl_we), 32'd0);

    // Flush with three pending plus a simultaneous incoming update.
    stall = 1'b1;
    push(10, 1); push(11, 3); push(12, 4);
    upd_pc_hash = 4'd7; upd_kind = 3'd2; upd_valid = 1'b1; flush = 1'b1;
    #1;
    check("flush_we", 32'(tbl_we), 32'd0);
    cyc();
    flush = 1'b0; upd_valid = 1'b0; stall = 1'b0; q_pc_hash = 4'd7;
    #1;
    check("flush_empty", 32'(tbl_we), 32'd0);
    check("flush_q7", 32'(q_kind), 32'd0);
    repeat (3) begin
      cyc();
      check("flush_nowrite", 32'(tbl_we), 32'd0);
    end
    q_pc_hash = 4'd10;
    #1;
    check("flush_q10", 32'(q_kind), 32'd0);

    // Undefined kind 6 is stored as NOT_JUMP.
    push(9, 4);
    push(9, 6);
    upd_valid = 1'b0;
    #1;
    check("k6_addr", 32'(tbl_waddr), 32'd9);
    check("k6_din", 32'(tbl_din), 32'd0);
    cyc();
    check("k6_ram", 32'(dut_ram[9]), 32'd0);
    check("k6_model", 32'(m_ram[9]), 32'd0);

    // Reset mid-drain with two entries still pending.
    stall = 1'b1;
    push(3, 1); push(4, 2); push(6, 5);
    upd_valid = 1'b0; stall = 1'b0;
    cyc();
    rstn = 1'b0;
    #1;
    check("mr_init", 32'(init_done), 32'd0);
    check("mr_ready", 32'(upd_ready), 32'd0);
    check("mr_we", 32'(tbl_we), 32'd1);
    check("mr_waddr", 32'(tbl_waddr), 32'd0);
    check("mr_qkind", 32'(q_kind), 32'd0);
    cyc();
    rstn = 1'b1;
    cyc();
    check("mr_sweep1", 32'(tbl_waddr), 32'd1);
    repeat (15) cyc();
    check("mr_init_hi", 32'(init_done), 32'd1);
    check("mr_empty", 32'(tbl_we), 32'd0);
    check("mr_ready_hi", 32'(upd_ready), 32'd1);

    for (int i = 0; i < N; i++) check("final_ram", 32'(dut_ram[i]), 32'(m_ram[i]));
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
